conv_engine: RTL and testbench
==============================

CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 The parameter DATA_W SHALL default to 16 and set the signed fixed-point word width of activations, weights and results.
REQ-002 The parameter FRAC_W SHALL default to 8 and set the number of fractional bits in every word.
REQ-003 The parameter ACC_W SHALL default to 40 and set the signed accumulator width.
REQ-004 The parameter NUM_IN SHALL default to 2 and set the number of input channels.
REQ-005 The parameter NUM_OUT SHALL default to 2 and set the number of output channels.
REQ-006 The parameter IN_DIM SHALL default to 8 and set the square input width and height.
REQ-007 The parameter K_DIM SHALL default to 3 and set the square kernel width and height.
REQ-008 The parameter STRIDE SHALL default to 1 and set the kernel step in x and y.
REQ-009 The derived localparam OUT_DIM SHALL equal (IN_DIM-K_DIM)/STRIDE+1.
REQ-010 There SHALL be one clock and an active-high asynchronous reset: clk, in, 1, rising-edge clock; rst, in, 1, asynchronous active-high reset.
REQ-011 The write port SHALL be: wr_en, in, 1, write strobe; wr_sel, in, 1, 0 selects activation memory and 1 selects weight memory; wr_addr, in, 16, flat address; wr_data, in, DATA_W, word.
REQ-012 The control port SHALL be: start, in, 1, begin a layer pass; busy, out, 1, pass in progress; done, out, 1, one-cycle pulse at the end of a pass.
REQ-013 The output stream SHALL be: out_valid, out, 1; out_ready, in, 1; out_data, out, DATA_W, result; out_ch, out, 16, channel index; out_y, out, 16, row index; out_x, out, 16, column index.

Function
REQ-014 Addresses SHALL map as follows: activation = (ch*IN_DIM+y)*IN_DIM+x; weight = ((o*NUM_IN+i)*K_DIM+ky)*K_DIM+kx.
REQ-015 A write with an address at or beyond the selected memory's depth SHALL be ignored.
REQ-016 A write asserted while busy is high SHALL be ignored.
REQ-017 The FSM SHALL have four states: IDLE -> MAC on start, MAC -> EMIT after the last MAC, EMIT -> MAC on handshake if outputs remain, EMIT -> DONE on handshake after the last output, DONE -> IDLE after one cycle.
REQ-018 start SHALL be ignored outside IDLE; busy SHALL be high in MAC, EMIT and DONE.
REQ-019 Memory reads SHALL be synchronous with one-cycle latency and one MAC per cycle, so MAC lasts NUM_IN*K_DIM*K_DIM+1 cycles per output, including one pipeline-fill cycle.
REQ-020 The accumulator SHALL clear when a new output begins, and each cycle SHALL add act*weight, a full 2*DATA_W product sign-extended to ACC_W.
REQ-021 The result SHALL be acc >>> FRAC_W (arithmetic shift), saturated to the signed DATA_W range.
REQ-022 Output order SHALL be channel-major, then y, then x; activation y = oy*STRIDE+ky and activation x = ox*STRIDE+kx.
REQ-023 out_valid SHALL be high only in EMIT, and out_data and the indices SHALL stay stable until out_valid && out_ready.
REQ-024 If start and wr_en coincide in IDLE, the write SHALL commit and SHALL be visible to the pass.

Reset
REQ-025 rst SHALL force the FSM to IDLE, clear the accumulator and counters, and drive busy, done, out_valid, out_data, out_ch, out_y and out_x to 0.
REQ-026 Memory contents SHALL NOT be reset, and an assertion of rst mid-pass SHALL abort the pass without emitting a done pulse.

Configuration
REQ-027 With CONV_ENGINE_RELU_EN defined, a saturated result below zero SHALL be output as 0; without it, signed results SHALL pass unchanged.

Structure
REQ-028 The shared package conv_pkg SHALL hold the FSM state enum, the wr_sel encodings and a saturation function.
REQ-029 The block SHALL instantiate one sub-module, conv_mac, containing the multiplier, accumulator, shift and saturation.

Verification
REQ-030 The bench SHALL cover: IN_DIM=4, K_DIM=3, NUM_IN=NUM_OUT=1, all activations and weights 256 (1.0) -> four outputs of 2304 (9.0) at (0,0,0),(0,0,1),(0,1,0),(0,1,1), then one done pulse.
REQ-031 The bench SHALL cover: IN_DIM=5, STRIDE=2, K_DIM=3, unit weights and activation[y][x]=256*x -> OUT_DIM=2, and row 0 = 2304 and 6912.
REQ-032 The bench SHALL cover: activations 32512 (127.0) and weights 32512 -> every out_data = 32767 (saturation).
REQ-033 The bench SHALL cover: out_ready held low for 10 cycles in EMIT -> out_valid stays high, payload unchanged, busy stays high, and no counter advances.
REQ-034 The bench SHALL cover: weights -256 and activations 256 -> out_data = 0 with CONV_ENGINE_RELU_EN and -2304 without.
REQ-035 The bench SHALL cover: rst asserted mid-MAC -> the next cycle shows busy=0 and out_valid=0 with no done pulse; a restarted pass then yields the same results as an uninterrupted one.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the conv_engine slice.
// Holds the FSM state enum, wr_sel encodings and the saturation helper.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic SEL_ACT = 1'b0;
  localparam logic SEL_WT  = 1'b1;

  // Clamp a signed value to the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_s(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate, arithmetic shift and saturation.
// Ports: clk, rst (async high), clr, en, a, w -> result.
// Macro CONV_ENGINE_RELU_EN clamps negative results to zero.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] a_x;
  logic signed [2*DATA_W-1:0] w_x;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sh;
  logic signed [63:0]         sat_v;
  logic        [DATA_W-1:0]   res;

  assign a_x    = (2*DATA_W)'($signed(a));
  assign w_x    = (2*DATA_W)'($signed(w));
  assign prod   = a_x * w_x;
  assign prod_x = ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

  assign sh    = acc >>> FRAC_W;
  assign sat_v = sat_s(64'(sh), DATA_W);
  assign res   = DATA_W'(sat_v);

`ifdef CONV_ENGINE_RELU_EN
  assign result = res[DATA_W-1] ? '0 : res;
`else
  assign result = res;
`endif

endmodule

// File: rtl/conv_engine.sv
// conv_engine: multi-channel 2-D convolution layer, one MAC per cycle.
// Ports: clk, rst, wr_*, start/busy/done, out_* stream (valid/ready).
// Macro CONV_ENGINE_RELU_EN (in conv_mac) zeroes negative results.
module conv_engine
  import conv_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 40,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2,
  parameter int IN_DIM  = 8,
  parameter int K_DIM   = 3,
  parameter int STRIDE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [15:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       out_ch,
  output logic [15:0]       out_y,
  output logic [15:0]       out_x
);

  localparam int OUT_DIM = (IN_DIM - K_DIM) / STRIDE + 1;
  localparam int N_TAPS  = NUM_IN * K_DIM * K_DIM;
  localparam int A_DEPTH = NUM_IN * IN_DIM * IN_DIM;
  localparam int W_DEPTH = NUM_OUT * N_TAPS;
  localparam int A_AW    = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int W_AW    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;

  state_e      state;
  logic [15:0] mac_cnt;
  logic [15:0] ci;
  logic [15:0] ky;
  logic [15:0] kx;
  logic [15:0] oc;
  logic [15:0] oy;
  logic [15:0] ox;

  logic [DATA_W-1:0] act_mem [A_DEPTH];
  logic [DATA_W-1:0] wt_mem  [W_DEPTH];
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_w;
  logic [A_AW-1:0]   a_addr;
  logic [W_AW-1:0]   w_addr;

  logic a_we;
  logic w_we;
  logic kx_end;
  logic ky_end;
  logic ci_end;
  logic ox_end;
  logic oy_end;
  logic oc_end;
  logic mac_last;
  logic mac_clr;
  logic mac_en;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_valid = (state == ST_EMIT);
  assign out_ch    = oc;
  assign out_y     = oy;
  assign out_x     = ox;

  assign a_we = wr_en && !busy && (wr_sel == SEL_ACT)
             && (32'(wr_addr) < A_DEPTH);
  assign w_we = wr_en && !busy && (wr_sel == SEL_WT)
             && (32'(wr_addr) < W_DEPTH);

  assign a_addr = A_AW'(
    (int'(ci) * IN_DIM + int'(oy) * STRIDE + int'(ky)) * IN_DIM
    + int'(ox) * STRIDE + int'(kx));
  assign w_addr = W_AW'(
    ((int'(oc) * NUM_IN + int'(ci)) * K_DIM + int'(ky)) * K_DIM
    + int'(kx));

  assign kx_end   = (kx == 16'(K_DIM - 1));
  assign ky_end   = (ky == 16'(K_DIM - 1));
  assign ci_end   = (ci == 16'(NUM_IN - 1));
  assign ox_end   = (ox == 16'(OUT_DIM - 1));
  assign oy_end   = (oy == 16'(OUT_DIM - 1));
  assign oc_end   = (oc == 16'(NUM_OUT - 1));
  assign mac_last = (mac_cnt == 16'(N_TAPS));

  // Cycle 0 of an output clears the accumulator while tap 0 is read;
  // cycles 1..N_TAPS consume the registered read data.
  assign mac_clr = (state == ST_MAC) && (mac_cnt == 16'd0);
  assign mac_en  = (state == ST_MAC) && (mac_cnt != 16'd0);

  // Memories are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (a_we) act_mem[wr_addr[A_AW-1:0]] <= wr_data;
    if (w_we) wt_mem[wr_addr[W_AW-1:0]]  <= wr_data;
    if (state == ST_MAC) begin
      rd_a <= act_mem[a_addr];
      rd_w <= wt_mem[w_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mac_cnt <= '0;
      ci      <= '0;
      ky      <= '0;
      kx      <= '0;
      oc      <= '0;
      oy      <= '0;
      ox      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_MAC;
            mac_cnt <= '0;
            ci      <= '0;
            ky      <= '0;
            kx      <= '0;
            oc      <= '0;
            oy      <= '0;
            ox      <= '0;
          end
        end
        ST_MAC: begin
          if (mac_last) begin
            state   <= ST_EMIT;
            mac_cnt <= '0;
          end else begin
            mac_cnt <= mac_cnt + 16'd1;
            // Tap walk wraps back to 0 after the last issue.
            if (!kx_end) begin
              kx <= kx + 16'd1;
            end else begin
              kx <= '0;
              if (!ky_end) begin
                ky <= ky + 16'd1;
              end else begin
                ky <= '0;
                ci <= ci_end ? 16'd0 : ci + 16'd1;
              end
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (oc_end && oy_end && ox_end) begin
              state <= ST_DONE;
              oc    <= '0;
              oy    <= '0;
              ox    <= '0;
            end else begin
              state <= ST_MAC;
              if (!ox_end) begin
                ox <= ox + 16'd1;
              end else begin
                ox <= '0;
                if (!oy_end) begin
                  oy <= oy + 16'd1;
                end else begin
                  oy <= '0;
                  oc <= oc + 16'd1;
                end
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  conv_mac #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (rd_a),
    .w     (rd_w),
    .result(out_data)
  );

endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: scoreboard bench, two conv_engine configurations.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_conv_engine;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en     [2];
  logic        wr_sel    [2];
  logic [15:0] wr_addr   [2];
  logic [15:0] wr_data   [2];
  logic        start     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data  [2];
  logic [15:0] out_ch    [2];
  logic [15:0] out_y     [2];
  logic [15:0] out_x     [2];

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt [2];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

`ifdef CONV_ENGINE_RELU_EN
  localparam logic [15:0] NEG_EXP = 16'h0000;
`else
  localparam logic [15:0] NEG_EXP = 16'hF700;
`endif

  always #5 clk = ~clk;

  conv_engine #(
    .DATA_W(16), .FRAC_W(8), .ACC_W(40),
    .NUM_IN(1), .NUM_OUT(1),
    .IN_DIM(4), .K_DIM(3), .STRIDE(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[0]), .wr_sel(wr_sel[0]),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .start(start[0]), .busy(busy[0]), .done(done[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_ch(out_ch[0]),
    .out_y(out_y[0]), .out_x(out_x[0])
  );

  conv_engine #(
    .DATA_W(16), .FRAC_W(8), .ACC_W(40),
    .NUM_IN(1), .NUM_OUT(1),
    .IN_DIM(5), .K_DIM(3), .STRIDE(2)
  ) u_b (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[1]), .wr_sel(wr_sel[1]),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .start(start[1]), .busy(busy[1]), .done(done[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_ch(out_ch[1]),
    .out_y(out_y[1]), .out_x(out_x[1])
  );

  function automatic void chk(string name, logic [63:0] got,
                              logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void pop_chk(int i);
    logic [63:0] got;
    logic [63:0] exp;
    int          sz;
    got = {out_data[i], out_ch[i], out_y[i], out_x[i]};
    sz  = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_out dut%0d: got %h expected none", i, got);
      return;
    end
    if (i == 0) exp = q0.pop_front();
    else        exp = q1.pop_front();
    chk($sformatf("out_dut%0d", i), got, exp);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done[i] === 1'b1) done_cnt[i]++;
      if (!rst && out_valid[i] && out_ready[i]) pop_chk(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int i, logic sel, int addr, logic [15:0] d,
                    logic st);
    wr_en[i]   = 1'b1;
    wr_sel[i]  = sel;
    wr_addr[i] = 16'(addr);
    wr_data[i] = d;
    start[i]   = st;
    tick();
    wr_en[i] = 1'b0;
    start[i] = 1'b0;
  endtask

  task automatic fill(int i, logic sel, int n, logic [15:0] d);
    for (int k = 0; k < n; k++) wr(i, sel, k, d, 1'b0);
  endtask

  task automatic push(int i, logic [15:0] d, int c, int y, int x);
    logic [63:0] e;
    e = {d, 16'(c), 16'(y), 16'(x)};
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push4(int i, logic [15:0] d0, logic [15:0] d1,
                       logic [15:0] d2, logic [15:0] d3);
    push(i, d0, 0, 0, 0);
    push(i, d1, 0, 0, 1);
    push(i, d2, 0, 1, 0);
    push(i, d3, 0, 1, 1);
  endtask

  task automatic go(int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int d0, string tag);
    int k;
    int sz;
    k = 0;
    while (done_cnt[i] == d0 && k < 3000) begin
      tick();
      k++;
    end
    repeat (4) tick();
    chk({tag, "_done_pulses"}, 64'(done_cnt[i] - d0), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy[i]), 64'd0);
    sz = (i == 0) ? q0.size() : q1.size();
    chk({tag, "_queue_left"}, 64'(sz), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_en[i] = 1'b0; wr_sel[i] = 1'b0; wr_addr[i] = '0;
      wr_data[i] = '0; start[i] = 1'b0; out_ready[i] = 1'b1;
      done_cnt[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_done", 64'(done[i]), 64'd0);
      chk("rst_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_payload",
          {out_data[i], out_ch[i], out_y[i], out_x[i]}, 64'd0);
    end
    rst = 1'b0;
    tick();

    // Unit data; last weight written in the same cycle as start.
    fill(0, SEL_ACT, 16, 16'd256);
    fill(0, SEL_WT, 8, 16'd256);
    push4(0, 16'd2304, 16'd2304, 16'd2304, 16'd2304);
    d0 = done_cnt[0];
    wr(0, SEL_WT, 8, 16'd256, 1'b1);
    chk("start_busy", 64'(busy[0]), 64'd1);
    wr(0, SEL_ACT, 0, 16'h0000, 1'b0);
    wait_done(0, d0, "unit");

    // Out-of-range write would alias act[0] if not rejected.
    wr(0, SEL_ACT, 16, 16'h0000, 1'b0);
    push4(0, 16'd2304, 16'd2304, 16'd2304, 16'd2304);
    d0 = done_cnt[0];
    go(0);
    wait_done(0, d0, "unit_again");

    // Saturation with a 10-cycle back-pressure stall.
    fill(0, SEL_ACT, 16, 16'd32512);
    fill(0, SEL_WT, 9, 16'd32512);
    out_ready[0] = 1'b0;
    push4(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    d0 = done_cnt[0];
    go(0);
    k = 0;
    while (!out_valid[0] && k < 100) begin
      tick();
      k++;
    end
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", 64'(out_valid[0]), 64'd1);
      chk("stall_busy", 64'(busy[0]), 64'd1);
      chk("stall_payload",
          {out_data[0], out_ch[0], out_y[0], out_x[0]},
          {16'h7FFF, 48'd0});
      tick();
    end
    out_ready[0] = 1'b1;
    wait_done(0, d0, "sat");

    // Negative result: ReLU-dependent.
    fill(0, SEL_ACT, 16, 16'd256);
    fill(0, SEL_WT, 9, 16'hFF00);
    push4(0, NEG_EXP, NEG_EXP, NEG_EXP, NEG_EXP);
    d0 = done_cnt[0];
    go(0);
    wait_done(0, d0, "neg");

    // Abort mid-MAC, then rerun on retained memory.
    d0 = done_cnt[0];
    go(0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_valid", 64'(out_valid[0]), 64'd0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("abort_no_done", 64'(done_cnt[0] - d0), 64'd0);
    push4(0, NEG_EXP, NEG_EXP, NEG_EXP, NEG_EXP);
    d0 = done_cnt[0];
    go(0);
    wait_done(0, d0, "restart");

    // Stride 2 on a 5x5 ramp: act[y][x] = 256*x.
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        wr(1, SEL_ACT, y * 5 + x, 16'(256 * x), 1'b0);
    fill(1, SEL_WT, 9, 16'd256);
    push4(1, 16'd2304, 16'd6912, 16'd2304, 16'd6912);
    d0 = done_cnt[1];
    go(1);
    wait_done(1, d0, "stride");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

endmodule
